neuron_mem_pp: RTL

- Parametrised ping-pong neuron activation memory for the MLP datapath: two banks of DEPTH x DATA_W.
- One bank, the read bank, holds the current layer's inputs; the other, the write bank, collects the current layer's outputs.
- An FSM sequences input-layer load, layer compute, and bank swap, so layers chain without copying.
- NUM_RD independent read ports feed parallel MAC lanes.

---
 rtl/neuron_pkg.sv | 13 +
 rtl/neuron_bank.sv | 47 ++++
 rtl/neuron_mem_pp.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and default sizes for the ping-pong neuron activation memory.
package neuron_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 12;
  localparam int LAYER_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    SWAP = 2'd3
  } state_t;
endpackage

// File: rtl/neuron_bank.sv
// One DEPTH x DATA_W activation bank: single write port, NUM_RD registered read ports.
// A read hitting the address written in the same cycle returns the new word.
module neuron_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] q
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_r [DEPTH];
  logic [NUM_RD*DATA_W-1:0] q_r;

  // Storage array, deliberately not reset so contents survive a reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read ports with write-first bypass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (re[i]) begin
          if (we && (waddr == raddr[i*ADDR_W +: ADDR_W])) begin
            q_r[i*DATA_W +: DATA_W] <= wdata;
          end else begin
            q_r[i*DATA_W +: DATA_W] <= mem_r[raddr[i*ADDR_W +: ADDR_W]];
          end
        end
      end
    end
  end

  assign q = q_r;
endmodule

// File: rtl/neuron_mem_pp.sv
// Ping-pong neuron activation memory: FSM sequencing load/run/swap, bank select,
// layer counters and per-port read-bank tracking so swaps never tear a read.
module neuron_mem_pp
  import neuron_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  input  logic                       start,
  input  logic [ADDR_W:0]            layer_size,
  input  logic                       last_layer,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       layer_done,
  output logic [LAYER_IDX_W-1:0]     layer_idx,
  output logic                       busy,
  output logic [1:0]                 state
);
  localparam logic [ADDR_W:0]          CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LAYER_IDX_W-1:0]   IDX_MAX = {LAYER_IDX_W{1'b1}};
  localparam logic [LAYER_IDX_W-1:0]   IDX_ONE = {{(LAYER_IDX_W-1){1'b0}}, 1'b1};

  state_t                     state_r, state_nxt_s;
  logic                       bank_sel_r;
  logic [ADDR_W:0]            wr_count_r, layer_size_r;
  logic [LAYER_IDX_W-1:0]     layer_idx_r;
  logic                       layer_done_r, load_ready_r, busy_r;
  logic [NUM_RD-1:0]          rd_valid_r, rd_bank_r;
  logic                       load_wr_s, run_wr_s, run_last_s;
  logic [1:0]                 bank_we_s;
  logic [ADDR_W-1:0]          bank_waddr_s;
  logic [DATA_W-1:0]          bank_wdata_s;
  logic [NUM_RD-1:0]          bank_re_s [2];
  logic [NUM_RD*DATA_W-1:0]   bank_q_s  [2];
  logic [NUM_RD*DATA_W-1:0]   rd_data_s;

  assign load_wr_s  = (state_r == LOAD) && load_valid;
  assign run_wr_s   = (state_r == RUN) && wr_en;
  assign run_last_s = run_wr_s && (wr_count_r == (layer_size_r - CNT_ONE));

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = LOAD; else state_nxt_s = IDLE;
      LOAD:    if (load_wr_s && load_last) state_nxt_s = RUN; else state_nxt_s = LOAD;
      RUN:     if (run_last_s) state_nxt_s = SWAP; else state_nxt_s = RUN;
      SWAP:    if (last_layer) state_nxt_s = IDLE; else state_nxt_s = RUN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Loads fill the read bank; layer outputs fill the other one
  always_comb begin
    bank_we_s[0] = (load_wr_s && !bank_sel_r) || (run_wr_s && bank_sel_r);
    bank_we_s[1] = (load_wr_s && bank_sel_r) || (run_wr_s && !bank_sel_r);
    if (state_r == LOAD) begin
      bank_waddr_s = load_addr;
      bank_wdata_s = load_data;
    end else begin
      bank_waddr_s = wr_addr;
      bank_wdata_s = wr_data;
    end
    bank_re_s[0] = rd_en & {NUM_RD{!bank_sel_r}};
    bank_re_s[1] = rd_en & {NUM_RD{bank_sel_r}};
  end

  // FSM, counters, bank select and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      bank_sel_r   <= 1'b0;
      wr_count_r   <= '0;
      layer_size_r <= '0;
      layer_idx_r  <= '0;
      layer_done_r <= 1'b0;
      load_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      rd_valid_r   <= '0;
      rd_bank_r    <= '0;
    end else begin
      state_r      <= state_nxt_s;
      layer_done_r <= (state_nxt_s == SWAP);
      load_ready_r <= (state_nxt_s == LOAD);
      busy_r       <= (state_nxt_s != IDLE);
      rd_valid_r   <= rd_en;
      if ((state_nxt_s == RUN) && (state_r != RUN)) begin
        layer_size_r <= layer_size;
      end
      if (run_last_s) begin
        wr_count_r <= '0;
      end else if (run_wr_s) begin
        wr_count_r <= wr_count_r + CNT_ONE;
      end
      if ((state_r == IDLE) && start) begin
        layer_idx_r <= '0;
      end else if ((state_r == SWAP) && (layer_idx_r != IDX_MAX)) begin
        layer_idx_r <= layer_idx_r + IDX_ONE;
      end
      if (state_r == SWAP) begin
        bank_sel_r <= ~bank_sel_r;
      end
      // Remember which bank each port read so held data stays stable across a swap
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          rd_bank_r[i] <= bank_sel_r;
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    neuron_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (bank_we_s[b]),
      .waddr (bank_waddr_s),
      .wdata (bank_wdata_s),
      .re    (bank_re_s[b]),
      .raddr (rd_addr),
      .q     (bank_q_s[b])
    );
  end

  // Per-port output select from the bank that served the last read
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_bank_r[i]) begin
        rd_data_s[i*DATA_W +: DATA_W] = bank_q_s[1][i*DATA_W +: DATA_W];
      end else begin
        rd_data_s[i*DATA_W +: DATA_W] = bank_q_s[0][i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data    = rd_data_s;
  assign rd_valid   = rd_valid_r;
  assign layer_done = layer_done_r;
  assign layer_idx  = layer_idx_r;
  assign load_ready = load_ready_r;
  assign busy       = busy_r;
  assign state      = state_r;
endmodule
